// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the stream arbiter: destination FSM state encoding
// and helpers for indexing the flattened grant matrix.
package stream_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Bit position of (destination, source) in the flattened grant matrix.
  function automatic int grant_index(input int dest_idx, input int src_idx, input int src_count);
    return dest_idx * src_count + src_idx;
  endfunction

  function automatic int ptr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at the priority
// pointer and returns a one-hot grant plus the pointer to use after that grant.
module rr_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int N_REQ = 5,
  parameter int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_next_ptr,
  output logic             o_any
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;
  int               w_sum;

  // The pointer is always kept below N_REQ, so one subtraction wraps the scan.
  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    w_sum      = 0;
    w_idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= N_REQ) begin
        w_sum = w_sum - N_REQ;
      end
      w_idx = PTR_W'(w_sum);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_next_ptr     = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/stream_arbiter.sv
// Packet-level stream arbiter: each destination locks onto one source by
// round-robin and holds it until the last beat of the packet is accepted.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o
);

  localparam int PTR_W = ptr_width(S_DATA_COUNT);

  logic [S_DATA_COUNT-1:0] w_row [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] w_src_busy;

  // A source already locked to some destination may not be picked by another.
  always_comb begin
    w_src_busy = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      w_src_busy = w_src_busy | w_row[i];
    end
  end

  always_comb begin
    s_ready_o = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      for (int j = 0; j < S_DATA_COUNT; j++) begin
        s_ready_o[j] = s_ready_o[j] | (w_row[i][j] & m_ready_i[i]);
      end
    end
  end

  for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_dest
    arb_state_e              r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [S_DATA_COUNT-1:0] r_grant;
    logic [S_DATA_COUNT-1:0] w_req;
    logic [S_DATA_COUNT-1:0] w_arb_grant;
    logic [PTR_W-1:0]        w_next_ptr;
    logic                    w_any;
    logic                    w_xfer_last;

    // Destination values outside the valid range never match any row.
    for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_req
      assign w_req[j] = s_valid_i[j] && !w_src_busy[j] &&
                        (s_dest_i[j*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(i));
      assign grant_o[grant_index(i, j, S_DATA_COUNT)] = r_grant[j];
    end

    rr_arbiter #(
      .N_REQ (S_DATA_COUNT),
      .PTR_W (PTR_W)
    ) u_rr_arbiter (
      .i_req      (w_req),
      .i_ptr      (r_ptr),
      .o_grant    (w_arb_grant),
      .o_next_ptr (w_next_ptr),
      .o_any      (w_any)
    );

    assign w_row[i]     = r_grant;
    assign m_valid_o[i] = |(r_grant & s_valid_i);
    assign m_last_o[i]  = |(r_grant & s_last_i);
    assign w_xfer_last  = m_valid_o[i] & m_ready_i[i] & m_last_o[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_ptr   <= '0;
        r_grant <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_any) begin
              r_grant <= w_arb_grant;
              r_ptr   <= w_next_ptr;
              r_state <= BUSY;
            end
          end
          BUSY: begin
            if (w_xfer_last) begin
              r_grant <= '0;
              r_state <= IDLE;
            end
          end
          default: begin
            r_grant <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a packet-level model.
module tb_stream_arbiter;

  localparam int S  = 5;
  localparam int M  = 3;
  localparam int TW = 2;

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b0;
  logic [S-1:0]   sValid = '0;
  logic [S*TW-1:0] sDest = '0;
  logic [S-1:0]   sLast  = '0;
  logic [M-1:0]   mReady = '0;
  logic [S-1:0]   sReady;
  logic [M-1:0]   mValid;
  logic [M-1:0]   mLast;
  logic [S*M-1:0] grant;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: which source owns each destination (-1 = free) and its pointer.
  int owner [M] = '{-1, -1, -1};
  int ptr   [M] = '{0, 0, 0};

  stream_arbiter #(
    .S_DATA_COUNT (S),
    .M_DATA_COUNT (M),
    .T_DEST_WIDTH (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (sValid),
    .s_dest_i  (sDest),
    .s_last_i  (sLast),
    .m_ready_i (mReady),
    .s_ready_o (sReady),
    .m_valid_o (mValid),
    .m_last_o  (mLast),
    .grant_o   (grant)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [S-1:0] v, input logic [S*TW-1:0] d,
                               input logic [S-1:0] l, input logic [M-1:0] r);
    sValid = v;
    sDest  = d;
    sLast  = l;
    mReady = r;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [S*TW-1:0] packDest(input int d4, input int d3, input int d2,
                                               input int d1, input int d0);
    return {2'(d4), 2'(d3), 2'(d2), 2'(d1), 2'(d0)};
  endfunction

  function automatic logic [31:0] bitAt(input int dIdx, input int sIdx);
    logic [31:0] b;
    b = '0;
    b[dIdx*S + sIdx] = 1'b1;
    return b;
  endfunction

  function automatic int destOf(input int j);
    return int'(sDest[j*TW +: TW]);
  endfunction

  function automatic logic [31:0] expGrant();
    logic [31:0] g;
    g = '0;
    for (int i = 0; i < M; i++) if (owner[i] >= 0) g[i*S + owner[i]] = 1'b1;
    return g;
  endfunction

  function automatic logic [31:0] expValid();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < M; i++) if (owner[i] >= 0) v[i] = sValid[owner[i]];
    return v;
  endfunction

  function automatic logic [31:0] expLast();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < M; i++) if (owner[i] >= 0) v[i] = sLast[owner[i]];
    return v;
  endfunction

  function automatic logic [31:0] expReady();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < M; i++) if (owner[i] >= 0 && mReady[i]) v[owner[i]] = 1'b1;
    return v;
  endfunction

  // Packet-level rules: a free destination picks the first eligible source at or
  // after its pointer; an owned destination is released when a last beat moves.
  task automatic modelStep();
    int nextOwner [M];
    bit busySrc [S];
    for (int j = 0; j < S; j++) busySrc[j] = 1'b0;
    for (int i = 0; i < M; i++) if (owner[i] >= 0) busySrc[owner[i]] = 1'b1;
    for (int i = 0; i < M; i++) begin
      nextOwner[i] = owner[i];
      if (owner[i] >= 0) begin
        int o;
        o = owner[i];
        if (sValid[o] && mReady[i] && sLast[o]) nextOwner[i] = -1;
      end else begin
        for (int k = 0; k < S; k++) begin
          int j;
          j = (ptr[i] + k) % S;
          if (sValid[j] && destOf(j) == i && !busySrc[j]) begin
            nextOwner[i] = j;
            ptr[i] = (j + 1) % S;
            break;
          end
        end
      end
    end
    for (int i = 0; i < M; i++) owner[i] = nextOwner[i];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) begin
        owner[i] = -1;
        ptr[i]   = 0;
      end
    end else begin
      modelStep();
    end
  end

  // Outputs are compared against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("model grant_o", grant, expGrant());
    checkOutput("model m_valid_o", mValid, expValid());
    checkOutput("model m_last_o", mLast, expLast());
    checkOutput("model s_ready_o", sReady, expReady());
  end

  initial begin
    logic rdy;
    int   beats;
    logic [S-1:0] rv;
    logic [S-1:0] rl;
    logic [S*TW-1:0] rd;

    applyStimulus('0, '0, '0, '0);
    waitCycles(2);
    checkOutput("reset grant", grant, 32'h0);
    checkOutput("reset s_ready", sReady, 32'h0);
    #2 rst_n = 1'b1;
    waitCycles(1);

    // Contention: sources 1, 3, 4 all to destination 2 with single-beat packets.
    applyStimulus(5'b11010, packDest(2, 2, 0, 2, 0), 5'b11111, 3'b111);
    waitCycles(1);
    checkOutput("contention first", grant, bitAt(2, 1));
    checkOutput("contention m_last", mLast, 32'h4);
    waitCycles(1);
    checkOutput("contention idle 1", grant, 32'h0);
    applyStimulus(5'b11000, packDest(2, 2, 0, 2, 0), 5'b11111, 3'b111);
    waitCycles(1);
    checkOutput("contention second", grant, bitAt(2, 3));
    waitCycles(1);
    checkOutput("contention idle 2", grant, 32'h0);
    applyStimulus(5'b10000, packDest(2, 2, 0, 2, 0), 5'b11111, 3'b111);
    waitCycles(1);
    checkOutput("contention third", grant, bitAt(2, 4));
    waitCycles(1);
    checkOutput("contention idle 3", grant, 32'h0);
    applyStimulus('0, '0, '0, 3'b111);
    waitCycles(1);

    // Wrap: move destination 0 pointer to 4, then sources 0 and 4 compete.
    applyStimulus(5'b01000, packDest(0, 0, 0, 0, 0), 5'b11111, 3'b111);
    waitCycles(1);
    checkOutput("wrap setup", grant, bitAt(0, 3));
    waitCycles(1);
    applyStimulus(5'b10001, packDest(0, 0, 0, 0, 0), 5'b11111, 3'b111);
    waitCycles(1);
    checkOutput("wrap source 4", grant, bitAt(0, 4));
    waitCycles(1);
    applyStimulus(5'b00001, packDest(0, 0, 0, 0, 0), 5'b11111, 3'b111);
    waitCycles(1);
    checkOutput("wrap source 0", grant, bitAt(0, 0));
    waitCycles(1);
    applyStimulus('0, '0, '0, 3'b111);
    waitCycles(1);

    // Parallel: source 0 to destination 1 and source 2 to destination 0.
    applyStimulus(5'b00101, packDest(0, 0, 0, 0, 1), 5'b00101, 3'b111);
    waitCycles(1);
    checkOutput("parallel grants", grant, 32'h24);
    waitCycles(1);
    applyStimulus('0, '0, '0, 3'b111);
    waitCycles(1);

    // Lock: 4-beat packet from source 1, toggling ready, destination changes mid-packet.
    applyStimulus(5'b00010, packDest(0, 0, 0, 0, 0), 5'b00000, 3'b110);
    waitCycles(1);
    checkOutput("lock grant", grant, bitAt(0, 1));
    checkOutput("lock stalled ready", sReady, 32'h0);
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      rdy = (c % 3 != 1);
      applyStimulus(5'b00010, packDest(0, 0, 0, 2, 0), (beats == 3) ? 5'b00010 : 5'b00000, {2'b11, rdy});
      checkOutput("lock held", grant, bitAt(0, 1));
      waitCycles(1);
      if (rdy) beats++;
    end
    checkOutput("lock row cleared", grant, 32'h0);
    applyStimulus('0, '0, '0, 3'b111);
    waitCycles(1);

    // Invalid destination: source 3 targets destination 3, which does not exist.
    applyStimulus(5'b01000, packDest(0, 3, 0, 0, 0), 5'b01000, 3'b111);
    for (int c = 0; c < 100; c++) begin
      waitCycles(1);
      checkOutput("invalid s_ready[3]", sReady[3], 32'h0);
      checkOutput("invalid grant column 3", {grant[13], grant[8], grant[3]}, 32'h0);
    end
    applyStimulus('0, '0, '0, 3'b111);
    waitCycles(1);

    // Reset mid-packet under back-pressure, then source 0 must win after release.
    applyStimulus(5'b00100, packDest(0, 0, 1, 0, 0), 5'b00000, 3'b000);
    waitCycles(1);
    checkOutput("backpressure grant", grant, bitAt(1, 2));
    waitCycles(5);
    checkOutput("backpressure held", grant, bitAt(1, 2));
    checkOutput("backpressure m_valid", mValid, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset grant", grant, 32'h0);
    checkOutput("async reset s_ready", sReady, 32'h0);
    checkOutput("async reset m_valid", mValid, 32'h0);
    checkOutput("async reset m_last", mLast, 32'h0);
    applyStimulus(5'b00101, packDest(0, 0, 1, 0, 1), 5'b00101, 3'b111);
    @(posedge clk);
    #3 rst_n = 1'b1;
    waitCycles(1);
    checkOutput("post reset source 0", grant, bitAt(1, 0));
    waitCycles(1);
    applyStimulus(5'b00100, packDest(0, 0, 1, 0, 1), 5'b00101, 3'b111);
    waitCycles(1);
    checkOutput("post reset source 2", grant, bitAt(1, 2));
    waitCycles(1);

    // Randomized traffic, with one asynchronous reset pulse in the middle.
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < S; j++) begin
        rv[j] = ($urandom_range(3) != 0);
        rl[j] = ($urandom_range(3) == 0);
        rd[j*TW +: TW] = 2'($urandom_range(3));
      end
      applyStimulus(rv, rd, rl, 3'($urandom));
      if (c == 1500) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      waitCycles(1);
    end

    applyStimulus('0, '0, '0, '0);
    waitCycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
